multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit_if.sv | 48 ++++
 rtl/multdiv_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if -- operand/control/result bundle for multdiv_unit.
//
// Signals (WIDTH = operand width):
//   data_operandA  [WIDTH]  multiplicand or dividend          (master -> slave)
//   data_operandB  [WIDTH]  multiplier or divisor             (master -> slave)
//   ctrl_MULT      [1]      single-cycle multiply start       (master -> slave)
//   ctrl_DIV       [1]      single-cycle divide start         (master -> slave)
//   ctrl_signed    [1]      two's-complement (1) / unsigned (0) operands
//   ctrl_flush     [1]      abort any operation in flight     (master -> slave)
//   data_result    [WIDTH]  low product word or quotient      (slave -> master)
//   data_exception [1]      overflow / divide-by-zero flag    (slave -> master)
//   data_resultRDY [1]      one-cycle completion pulse        (slave -> master)
//   busy           [1]      operation in progress             (slave -> master)
//   data_result_hi [WIDTH]  high product word or remainder, only when
//                           MULTDIV_HIGH_WORD_EN is defined   (slave -> master)
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             ctrl_signed;
  logic             ctrl_flush;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
`ifdef MULTDIV_HIGH_WORD_EN
  logic [WIDTH-1:0] data_result_hi;
`endif

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_signed, ctrl_flush,
`ifdef MULTDIV_HIGH_WORD_EN
    input  data_result_hi,
`endif
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_signed, ctrl_flush,
`ifdef MULTDIV_HIGH_WORD_EN
    output data_result_hi,
`endif
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit -- iterative multiply / divide unit.
//
// Multiply: radix-4 Booth, one recoded digit per cycle (WIDTH/2 cycles).
// Divide:   non-restoring on magnitudes, one quotient bit per cycle
//           (WIDTH cycles) plus one sign-correction cycle.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - multdiv_unit_if.slave (operands, start/flush controls,
//            result, exception, completion pulse, busy)
//
// Parameters:
//   WIDTH          - operand/result width, even and >= 4
//   SIGNED_DEFAULT - operand interpretation expected when ctrl_signed is tied
//
// Optional feature macro: MULTDIV_HIGH_WORD_EN adds bus.data_result_hi
// (upper product word after MUL, remainder after DIV).
module multdiv_unit #(
  parameter int WIDTH          = 32,
  parameter bit SIGNED_DEFAULT = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_unit_if.slave bus
);

  // Accumulator carries headroom above the WIDTH+2-bit partial products so the
  // running Booth sum and the doubled divide remainder never wrap.
  localparam int AW = WIDTH + 4;
  localparam int CW = $clog2(WIDTH + 2);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("multdiv_unit: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [AW-1:0]    acc;       // Booth high part / divide partial remainder
  logic [WIDTH-1:0]        lo;        // multiplier-and-low-product / dividend-and-quotient
  logic                    qm1;       // Booth bit to the right of lo[0]
  logic signed [WIDTH:0]   mcand;     // multiplicand, extended by one sign bit
  logic [WIDTH-1:0]        dvsr;      // divisor magnitude
  logic                    sgn;
  logic                    mul_corr;  // unsigned multiplier with MSB set
  logic                    neg_q;
  logic                    neg_r;
  logic                    div_exc;
  logic [WIDTH-1:0]        result_q;
  logic                    exc_q;
  logic                    rdy_q;
  logic                    busy_q;
`ifdef MULTDIV_HIGH_WORD_EN
  logic [WIDTH-1:0]        result_hi_q;
`endif

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  // Product fits in WIDTH bits when the upper WIDTH+1 bits are a pure sign
  // extension (signed) or the upper WIDTH bits are zero (unsigned).
  function automatic logic mul_overflow(input logic [WIDTH-1:0] hi,
                                        input logic [WIDTH-1:0] lo_w,
                                        input logic             s);
    logic [WIDTH:0] top;
    top = {hi, lo_w[WIDTH-1]};
    if (s) return !((&top) || !(|top));
    return |hi;
  endfunction

  // Start decode and operand conditioning
  logic             start_ok;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_ovf_in;

  assign start_ok   = (bus.ctrl_MULT ^ bus.ctrl_DIV) && !bus.ctrl_flush &&
                      (state == IDLE || state == DONE);
  assign a_neg      = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
  assign b_neg      = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
  assign a_mag      = neg_if(a_neg, bus.data_operandA);
  assign b_mag      = neg_if(b_neg, bus.data_operandB);
  assign div_ovf_in = bus.ctrl_signed &&
                      (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.data_operandB == {WIDTH{1'b1}});

  // Booth step
  logic signed [AW-1:0] mcand_x;
  logic signed [AW-1:0] pp;
  logic signed [AW-1:0] mul_sum;
  logic signed [AW-1:0] mul_acc_nxt;
  logic [WIDTH-1:0]     mul_lo_nxt;
  logic [WIDTH-1:0]     mul_hi_fix;

  always_comb begin
    mcand_x = {{(AW-WIDTH-1){mcand[WIDTH]}}, mcand};
    case ({lo[1:0], qm1})
      3'b001, 3'b010: pp = mcand_x;
      3'b011:         pp = mcand_x <<< 1;
      3'b100:         pp = -(mcand_x <<< 1);
      3'b101, 3'b110: pp = -mcand_x;
      default:        pp = '0;
    endcase
    mul_sum     = acc + pp;
    mul_acc_nxt = mul_sum >>> 2;
    mul_lo_nxt  = {mul_sum[1:0], lo[WIDTH-1:2]};
    // Booth treats the multiplier as signed; an unsigned multiplier with its
    // MSB set is short by 2^WIDTH, so add the multiplicand into the high word.
    mul_hi_fix  = mul_acc_nxt[WIDTH-1:0] + (mul_corr ? mcand[WIDTH-1:0] : '0);
  end

  // Non-restoring divide step and final correction
  logic signed [AW-1:0] dvsr_x;
  logic signed [AW-1:0] rem_sh;
  logic signed [AW-1:0] div_rem_nxt;
  logic [WIDTH-1:0]     div_lo_nxt;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     div_quot;
  logic [WIDTH-1:0]     div_rem;

  always_comb begin
    dvsr_x      = {{(AW-WIDTH){1'b0}}, dvsr};
    rem_sh      = {acc[AW-2:0], lo[WIDTH-1]};
    div_rem_nxt = acc[AW-1] ? (rem_sh + dvsr_x) : (rem_sh - dvsr_x);
    div_lo_nxt  = {lo[WIDTH-2:0], ~div_rem_nxt[AW-1]};
    // A negative final remainder is restored by one divisor add; the true
    // value lies in [0, divisor) so the low WIDTH bits are exact.
    rem_fix     = acc[AW-1] ? (acc[WIDTH-1:0] + dvsr) : acc[WIDTH-1:0];
    div_quot    = neg_if(neg_q, lo);
    div_rem     = neg_if(neg_r, rem_fix);
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      lo          <= '0;
      qm1         <= 1'b0;
      mcand       <= '0;
      dvsr        <= '0;
      sgn         <= SIGNED_DEFAULT;
      mul_corr    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_exc     <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULTDIV_HIGH_WORD_EN
      result_hi_q <= '0;
`endif
    end else if (bus.ctrl_flush) begin
      state  <= IDLE;
      cnt    <= '0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            busy_q <= 1'b1;
            sgn    <= bus.ctrl_signed;
            acc    <= '0;
            qm1    <= 1'b0;
            if (bus.ctrl_MULT) begin
              state    <= MUL;
              cnt      <= CW'(WIDTH / 2);
              lo       <= bus.data_operandB;
              mcand    <= {bus.ctrl_signed & bus.data_operandA[WIDTH-1], bus.data_operandA};
              mul_corr <= !bus.ctrl_signed & bus.data_operandB[WIDTH-1];
            end else begin
              state   <= DIV;
              cnt     <= CW'(WIDTH + 1);
              lo      <= a_mag;
              dvsr    <= b_mag;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              div_exc <= (bus.data_operandB == '0) || div_ovf_in;
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          acc <= mul_acc_nxt;
          lo  <= mul_lo_nxt;
          qm1 <= lo[1];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b1;
            result_q <= mul_lo_nxt;
            exc_q    <= mul_overflow(mul_hi_fix, mul_lo_nxt, sgn);
`ifdef MULTDIV_HIGH_WORD_EN
            result_hi_q <= mul_hi_fix;
`endif
          end
        end
        DIV: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Sign-correction cycle; a zero divisor forces a zero quotient.
            state    <= DONE;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b1;
            result_q <= (dvsr == '0) ? '0 : div_quot;
            exc_q    <= div_exc;
`ifdef MULTDIV_HIGH_WORD_EN
            result_hi_q <= div_rem;
`endif
          end else begin
            acc <= div_rem_nxt;
            lo  <= div_lo_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MULTDIV_HIGH_WORD_EN
  logic unused_rem;
  assign unused_rem = ^div_rem;
`endif

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
`ifdef MULTDIV_HIGH_WORD_EN
  assign bus.data_result_hi = result_hi_q;
`endif

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit -- directed and randomized checks of multdiv_unit (WIDTH=32)
// against a plain-arithmetic reference model.
module tb_multdiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  multdiv_unit_if #(.WIDTH(W)) bus ();
  multdiv_unit #(.WIDTH(W), .SIGNED_DEFAULT(1'b1)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision arithmetic on 64-bit integers.
  task automatic model(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [31:0] hi, output logic exc,
                       output bit hk);
    longint      sa, sb, p, q, r;
    logic [63:0] pu, pv;
    logic signed [31:0] lo32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hk = 1'b1;
    if (!is_div) begin
      if (sgn) begin
        p    = sa * sb;
        pv   = p;
        lo32 = pv[31:0];
        res  = pv[31:0];
        hi   = pv[63:32];
        exc  = (longint'(lo32) != p);
      end else begin
        pu  = {32'b0, a} * {32'b0, b};
        res = pu[31:0];
        hi  = pu[63:32];
        exc = (pu[63:32] != 32'b0);
      end
    end else if (b == 32'b0) begin
      res = 32'b0; hi = 32'b0; exc = 1'b1; hk = 1'b0;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000; hi = 32'b0; exc = 1'b1;
    end else if (sgn) begin
      q = sa / sb; r = sa % sb;
      pv = q; res = pv[31:0];
      pv = r; hi  = pv[31:0];
      exc = 1'b0;
    end else begin
      res = a / b; hi = a % b; exc = 1'b0;
    end
  endtask

  // Drives a start for exactly one edge, then scrambles the operand inputs.
  task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b, input bit sgn);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_signed   = sgn;
    bus.ctrl_MULT     = !is_div;
    bus.ctrl_DIV      = is_div;
    @(posedge clk); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
    bus.ctrl_signed   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] er,
                           input logic ee, input logic [31:0] eh, input bit hk);
    int lat;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.data_resultRDY) begin
        lat = i;
        break;
      end
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".res"}, bus.data_result, er);
    check({tag, ".exc"}, bus.data_exception, ee);
`ifdef MULTDIV_HIGH_WORD_EN
    if (hk) check({tag, ".hi"}, bus.data_result_hi, eh);
`else
    if (hk && eh === 32'bx) check({tag, ".hi"}, 1'b0, 1'b1);
`endif
  endtask

  task automatic run_dir(input string tag, input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input bit sgn, input logic [31:0] er, input logic ee, input logic [31:0] eh,
                         input bit hk, input bit linger);
    start_op(is_div, a, b, sgn);
    check({tag, ".busy"}, bus.busy, 1'b1);
    wait_done(tag, is_div ? 33 : 16, er, ee, eh, hk);
    if (linger) begin
      @(posedge clk); #1;
      check({tag, ".rdy_off"}, bus.data_resultRDY, 1'b0);
      check({tag, ".hold"}, bus.data_result, er);
    end
  endtask

  task automatic run_model(input string tag, input bit is_div, input logic [31:0] a,
                           input logic [31:0] b, input bit sgn, input bit linger);
    logic [31:0] er, eh;
    logic        ee;
    bit          hk;
    model(is_div, sgn, a, b, er, eh, ee, hk);
    run_dir(tag, is_div, a, b, sgn, er, ee, eh, hk, linger);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] er, eh;
    logic        ee;
    bit          hk;
    int          rdy_seen;

    rst_n             = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.ctrl_signed   = 1'b1;
    bus.ctrl_flush    = 1'b0;
    @(posedge clk); #1;
    check("rst.res",  bus.data_result, 32'b0);
    check("rst.exc",  bus.data_exception, 1'b0);
    check("rst.rdy",  bus.data_resultRDY, 1'b0);
    check("rst.busy", bus.busy, 1'b0);
`ifdef MULTDIV_HIGH_WORD_EN
    check("rst.hi",   bus.data_result_hi, 32'b0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed values
    run_dir("smul", 1'b0, -32'sd7, 32'sd6, 1'b1, 32'hFFFF_FFD6, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_dir("umul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 1'b1, 32'h1, 1'b1, 1'b1);
    run_dir("sdiv", 1'b1, -32'sd17, 32'sd5, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1);
    run_dir("div0", 1'b1, 32'd5, 32'd0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    run_dir("b2b_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 32'h0, 1'b1, 1'b1);

    // Flush five cycles into a divide
    start_op(1'b1, 32'd1000, 32'd7, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    bus.ctrl_flush = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_flush = 1'b0;
    check("flush.busy", bus.busy, 1'b0);
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.data_resultRDY) rdy_seen++;
    end
    check("flush.no_rdy", rdy_seen, 0);

    // Both starts high: ignored
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV  = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    check("both.busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    check("both.busy2", bus.busy, 1'b0);
    check("both.rdy", bus.data_resultRDY, 1'b0);

    // Reset mid-multiply, then a start on the first edge after release
    start_op(1'b0, 32'd12345, 32'd678, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst.res",  bus.data_result, 32'b0);
    check("midrst.exc",  bus.data_exception, 1'b0);
    check("midrst.rdy",  bus.data_resultRDY, 1'b0);
    check("midrst.busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_model("post_rst", 1'b0, 32'd123456, -32'sd789, 1'b1, 1'b1);

    // Start while busy is ignored; the original product completes
    model(1'b0, 1'b1, 32'd98765, -32'sd4321, er, eh, ee, hk);
    start_op(1'b0, 32'd98765, -32'sd4321, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd3;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_MULT     = 1'b0;
    wait_done("busy_start", 12, er, ee, eh, hk);

    // Randomized operations, some back-to-back
    for (int i = 0; i < 48; i++) begin
      run_model($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), pick(), pick(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
